// File: rtl/cmp_config_receiver.sv
// Per-core receiver for the comparator-configuration broadcast: pauses the core,
// waits for it to drain, loads salt/count/hashes into comparator memory, then handshakes.
module cmp_config_receiver #(
   parameter int SALT_WIDTH = 12,
   parameter int HASH_WIDTH = 35,
   parameter int ADDR_MSB   = 11
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    new_cmp_config,
   input  logic                    core_idle,
   output logic                    core_pause,
   input  logic                    cfg_valid,
   input  logic [HASH_WIDTH-1:0]   cfg_data,
   output logic                    cfg_ready,
   output logic                    mem_wr_en,
   output logic [ADDR_MSB:0]       mem_wr_addr,
   output logic [HASH_WIDTH-1:0]   mem_wr_data,
   output logic [SALT_WIDTH-1:0]   salt,
   output logic [ADDR_MSB+1:0]     num_hashes,
   output logic                    cmp_config_applied,
   input  logic                    all_cmp_config_applied,
   output logic                    cfg_error
);

   localparam int CW = ADDR_MSB + 2;
   localparam logic [CW-1:0] CAPACITY = {1'b1, {(ADDR_MSB+1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_LOAD_SALT,
      S_LOAD_COUNT,
      S_LOAD_HASHES,
      S_APPLIED
   } state_t;

   state_t                  state_q, state_d;
   logic [SALT_WIDTH-1:0]   salt_q, salt_d;
   logic [CW-1:0]           num_hashes_q, num_hashes_d;
   logic                    cfg_error_q, cfg_error_d;
   logic [CW-1:0]           addr_q, addr_d;
   logic [CW-1:0]           remaining_q, remaining_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_MSB:0]       wr_addr_q, wr_addr_d;
   logic [HASH_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                    xfer;
   logic [CW-1:0]           count_w;

   // Ready is a pure decode of the state register, so cfg_valid never loops back into it.
   assign cfg_ready          = (state_q == S_LOAD_SALT) || (state_q == S_LOAD_COUNT) ||
                               (state_q == S_LOAD_HASHES);
   assign core_pause         = (state_q != S_IDLE);
   assign cmp_config_applied = (state_q == S_APPLIED);
   assign xfer               = cfg_valid & cfg_ready;
   assign count_w            = cfg_data[ADDR_MSB+1:0];

   always_comb begin
      state_d      = state_q;
      salt_d       = salt_q;
      num_hashes_d = num_hashes_q;
      cfg_error_d  = cfg_error_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      case (state_q)
         S_IDLE: begin
            if (new_cmp_config) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (core_idle) state_d = S_LOAD_SALT;
         end
         S_LOAD_SALT: begin
            if (xfer) begin
               salt_d  = cfg_data[SALT_WIDTH-1:0];
               state_d = S_LOAD_COUNT;
            end
         end
         S_LOAD_COUNT: begin
            if (xfer) begin
               // Oversized counts are still fully consumed; only the stored count is clamped.
               if (count_w > CAPACITY) begin
                  cfg_error_d  = 1'b1;
                  num_hashes_d = CAPACITY;
               end else begin
                  cfg_error_d  = 1'b0;
                  num_hashes_d = count_w;
               end
               remaining_d = count_w;
               addr_d      = '0;
               state_d     = (count_w == '0) ? S_APPLIED : S_LOAD_HASHES;
            end
         end
         S_LOAD_HASHES: begin
            if (xfer) begin
               if (addr_q < CAPACITY) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q[ADDR_MSB:0];
                  wr_data_d = cfg_data;
               end
               addr_d      = addr_q + CW'(1);
               remaining_d = remaining_q - CW'(1);
               if (remaining_q == CW'(1)) state_d = S_APPLIED;
            end
         end
         S_APPLIED: begin
            if (all_cmp_config_applied) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q      <= S_IDLE;
         salt_q       <= '0;
         num_hashes_q <= '0;
         cfg_error_q  <= 1'b0;
         addr_q       <= '0;
         remaining_q  <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         salt_q       <= salt_d;
         num_hashes_q <= num_hashes_d;
         cfg_error_q  <= cfg_error_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign mem_wr_en   = wr_en_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign salt        = salt_q;
   assign num_hashes  = num_hashes_q;
   assign cfg_error   = cfg_error_q;

endmodule

// File: tb/tb_cmp_config_receiver.sv
// Randomized bench for cmp_config_receiver with a word-count based reference model
// (small memory: capacity 4) checked every cycle, plus literal directed checks.
module tb_cmp_config_receiver;

   localparam int SW  = 12;
   localparam int HW  = 35;
   localparam int AM  = 1;
   localparam int CAP = 4;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic            new_cmp_config;
   logic            core_idle;
   logic            core_pause;
   logic            cfg_valid;
   logic [HW-1:0]   cfg_data;
   logic            cfg_ready;
   logic            mem_wr_en;
   logic [AM:0]     mem_wr_addr;
   logic [HW-1:0]   mem_wr_data;
   logic [SW-1:0]   salt;
   logic [AM+1:0]   num_hashes;
   logic            cmp_config_applied;
   logic            all_cmp_config_applied;
   logic            cfg_error;

   cmp_config_receiver #(.SALT_WIDTH(SW), .HASH_WIDTH(HW), .ADDR_MSB(AM)) dut (
      .CLK(CLK), .RST_N(RST_N), .new_cmp_config(new_cmp_config), .core_idle(core_idle),
      .core_pause(core_pause), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .salt(salt), .num_hashes(num_hashes),
      .cmp_config_applied(cmp_config_applied),
      .all_cmp_config_applied(all_cmp_config_applied), .cfg_error(cfg_error)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // reference model: progress of a configuration measured in words consumed
   bit            m_busy, m_drained, m_applied, m_err, m_wr_en, m_xfer;
   logic [SW-1:0] m_salt;
   int            m_nh, m_words, m_count, m_wr_addr;
   logic [HW-1:0] m_wr_data;

   // source and capture
   logic [HW-1:0] src_q[$];
   logic [HW-1:0] cap_mem [CAP];
   int            cap_n;
   int            bubble_pct;
   bit            spur_en;
   int            first_ready, idle_rise;
   logic [HW-1:0] basic_h [3];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [HW-1:0] rnd35();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[HW-1:0];
   endfunction

   task automatic model_step();
      int idx;
      m_wr_en = 0;
      m_xfer  = 0;
      if (!RST_N) begin
         m_busy = 0; m_drained = 0; m_applied = 0; m_err = 0;
         m_salt = '0; m_nh = 0; m_words = 0; m_count = 0;
      end else if (!m_busy) begin
         if (new_cmp_config) begin
            m_busy = 1; m_drained = 0; m_words = 0;
         end
      end else if (!m_drained) begin
         m_drained = core_idle;
      end else if (m_applied) begin
         if (all_cmp_config_applied) begin
            m_busy = 0; m_applied = 0;
         end
      end else if (cfg_valid) begin
         m_xfer = 1;
         if (m_words == 0) begin
            m_salt = cfg_data[SW-1:0];
         end else if (m_words == 1) begin
            m_count   = int'(cfg_data[AM+1:0]);
            m_err     = (m_count > CAP);
            m_nh      = m_err ? CAP : m_count;
            m_applied = (m_count == 0);
         end else begin
            idx = m_words - 2;
            if (idx < CAP) begin
               m_wr_en = 1; m_wr_addr = idx; m_wr_data = cfg_data;
            end
            m_applied = (idx == m_count - 1);
         end
         m_words++;
      end
   endtask

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   initial forever begin
      @(negedge CLK);
      if (mem_wr_en === 1'b1) begin
         cap_mem[mem_wr_addr] = mem_wr_data;
         cap_n++;
      end
      if (chk_en) begin
         check("core_pause", 64'(core_pause), 64'(m_busy));
         check("cfg_ready", 64'(cfg_ready), 64'(m_busy && m_drained && !m_applied));
         check("applied", 64'(cmp_config_applied), 64'(m_applied));
         check("salt", 64'(salt), 64'(m_salt));
         check("num_hashes", 64'(num_hashes), 64'(m_nh));
         check("cfg_error", 64'(cfg_error), 64'(m_err));
         check("mem_wr_en", 64'(mem_wr_en), 64'(m_wr_en));
         if (m_wr_en) begin
            check("mem_wr_addr", 64'(mem_wr_addr), 64'(m_wr_addr));
            check("mem_wr_data", 64'(mem_wr_data), 64'(m_wr_data));
         end
      end
   end

   task automatic cycle();
      @(posedge CLK);
      #1;
      new_cmp_config         = 0;
      all_cmp_config_applied = 0;
      if (m_xfer) begin
         void'(src_q.pop_front());
         cfg_valid = 0;
      end
      if (src_q.size() == 0) cfg_valid = 0;
      else if (!cfg_valid) cfg_valid = ($urandom_range(0, 99) >= bubble_pct);
      cfg_data = cfg_valid ? src_q[0] : rnd35();
      if (spur_en && $urandom_range(0, 3) == 0) begin
         if (m_busy && m_drained && !m_applied) new_cmp_config = 1;
         if (m_busy && !m_drained) all_cmp_config_applied = 1;
      end
   endtask

   task automatic run_config(input logic [SW-1:0] s, input int c, input int bubble,
                             input int idle_dly, input bit spur, input int rst_after,
                             input bit fixed_h, output int lat);
      logic [HW-1:0] w;
      int n;
      bubble_pct = bubble;
      spur_en    = 0;
      cap_n      = 0;
      src_q.delete();
      w = rnd35(); w[SW-1:0] = s;            src_q.push_back(w);
      w = rnd35(); w[AM+1:0] = (AM+2)'(c);   src_q.push_back(w);
      for (int i = 0; i < c; i++) src_q.push_back((fixed_h && i < 3) ? basic_h[i] : rnd35());
      core_idle      = (idle_dly == 0);
      new_cmp_config = 1;
      cfg_valid      = 1;
      cfg_data       = src_q[0];
      lat = -1; first_ready = -1; idle_rise = 0;
      for (n = 1; n <= 400 && lat == -1; n++) begin
         cycle();
         spur_en = spur;
         if (n == idle_dly) begin core_idle = 1; idle_rise = n; end
         if (cfg_ready && first_ready < 0) first_ready = n;
         if (cmp_config_applied) lat = n;
         if (rst_after >= 0 && (2 + c - src_q.size()) == 2 + rst_after) begin
            RST_N = 0;
            cycle();
            RST_N = 1;
            src_q.delete();
            cfg_valid = 0;
            spur_en = 0;
            lat = -2;
         end
      end
      spur_en = 0;
      if (lat == -1) begin
         check("applied_timeout", 64'(cmp_config_applied), 64'd1);
         return;
      end
      if (lat == -2) return;
      repeat ($urandom_range(0, 3)) cycle();
      all_cmp_config_applied = 1;
      cycle();
      check("release_applied", 64'(cmp_config_applied), 64'd0);
      check("release_pause", 64'(core_pause), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_pause"}, 64'(core_pause), 64'd0);
      check({tag, "_ready"}, 64'(cfg_ready), 64'd0);
      check({tag, "_applied"}, 64'(cmp_config_applied), 64'd0);
      check({tag, "_salt"}, 64'(salt), 64'd0);
      check({tag, "_nh"}, 64'(num_hashes), 64'd0);
      check({tag, "_err"}, 64'(cfg_error), 64'd0);
      check({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
   endtask

   initial begin
      int lat;
      basic_h[0] = 35'h1_1111_1111;
      basic_h[1] = 35'h2_2222_2222;
      basic_h[2] = 35'h3_3333_3333;
      RST_N = 0; new_cmp_config = 0; core_idle = 0; cfg_valid = 0; cfg_data = '0;
      all_cmp_config_applied = 0; bubble_pct = 0; spur_en = 0;
      cycle();
      chk_en = 1;
      cycle();
      check_zero_outputs("reset");
      RST_N = 1;
      cycle();

      run_config(12'h5A3, 3, 0, 0, 0, -1, 1, lat);
      $display("basic: latency=%0d writes=%0d", lat, cap_n);
      check("basic_latency", 64'(lat), 64'd7);
      check("basic_salt", 64'(salt), 64'h5A3);
      check("basic_nh", 64'(num_hashes), 64'd3);
      check("basic_writes", 64'(cap_n), 64'd3);
      check("basic_h0", 64'(cap_mem[0]), 64'h1_1111_1111);
      check("basic_h1", 64'(cap_mem[1]), 64'h2_2222_2222);
      check("basic_h2", 64'(cap_mem[2]), 64'h3_3333_3333);

      run_config(12'h0F0, 2, 0, 20, 1, -1, 0, lat);
      $display("drain: latency=%0d ready_after_idle=%0d", lat, first_ready - idle_rise);
      check("drain_ready_delay", 64'(first_ready - idle_rise), 64'd1);
      check("drain_latency", 64'(lat), 64'd25);
      check("drain_writes", 64'(cap_n), 64'd2);

      run_config(12'h001, 0, 0, 0, 0, -1, 0, lat);
      $display("zero: latency=%0d writes=%0d", lat, cap_n);
      check("zero_latency", 64'(lat), 64'd4);
      check("zero_writes", 64'(cap_n), 64'd0);
      check("zero_nh", 64'(num_hashes), 64'd0);

      run_config(12'h777, 6, 0, 0, 0, -1, 0, lat);
      $display("overflow: latency=%0d writes=%0d", lat, cap_n);
      check("ovf_latency", 64'(lat), 64'd10);
      check("ovf_writes", 64'(cap_n), 64'd4);
      check("ovf_nh", 64'(num_hashes), 64'd4);
      check("ovf_err", 64'(cfg_error), 64'd1);

      run_config(12'h222, 2, 0, 0, 0, -1, 0, lat);
      $display("after overflow: latency=%0d err=%0d", lat, cfg_error);
      check("clr_err", 64'(cfg_error), 64'd0);
      check("clr_nh", 64'(num_hashes), 64'd2);

      run_config(12'(rnd35()), 4, 50, 2, 1, -1, 0, lat);
      $display("bubbles: latency=%0d writes=%0d", lat, cap_n);
      check("bubble_writes", 64'(cap_n), 64'd4);

      run_config(12'(rnd35()), 5, 30, 0, 0, 2, 0, lat);
      $display("reset mid-load");
      check_zero_outputs("midrst");

      run_config(12'h3C3, 3, 0, 0, 0, -1, 0, lat);
      $display("post reset: latency=%0d writes=%0d", lat, cap_n);
      check("post_rst_latency", 64'(lat), 64'd7);
      check("post_rst_salt", 64'(salt), 64'h3C3);

      for (int k = 0; k < 25; k++) begin
         int c;
         c = $urandom_range(0, 7);
         run_config(12'(rnd35()), c, $urandom_range(0, 60), $urandom_range(0, 4), 1, -1, 0, lat);
         $display("random %0d: count=%0d latency=%0d writes=%0d", k, c, lat, cap_n);
         check("rand_writes", 64'(cap_n), 64'((c > CAP) ? CAP : c));
      end

      repeat (3) cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_config_receiver.md
Name: cmp_config_receiver

Overview:
- Per-core responder for the comparator-configuration broadcast. One instance per descrypt core; N instances feed the N-bit cmp_config_applied vector of the distributor.
- On new_cmp_config it pauses the core and waits for in-flight candidates to drain. It then loads salt, hash count and hashes from a broadcast word stream into the local comparator memory.
- It raises cmp_config_applied and holds the core paused until the distributor answers with all_cmp_config_applied.

Parameters:
- SALT_WIDTH, 12, width of salt field taken from cfg_data LSBs.
- HASH_WIDTH, 35, width of stored comparator hash and of cfg_data.
- ADDR_MSB, 11, MSB of comparator memory address; capacity = 2^(ADDR_MSB+1) hashes.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST_N  in  1  reset; synchronous, active-low.
- new_cmp_config  in  1  one-cycle pulse: new configuration follows.
- core_idle  in  1  core has no candidates in flight.
- core_pause  out  1  core must not issue new candidates.
- cfg_valid  in  1  cfg_data valid.
- cfg_data  in  HASH_WIDTH  config word.
- cfg_ready  out  1  receiver accepts a word; transfer = cfg_valid & cfg_ready.
- mem_wr_en  out  1  comparator memory write strobe.
- mem_wr_addr  out  ADDR_MSB+1  write address.
- mem_wr_data  out  HASH_WIDTH  write data.
- salt  out  SALT_WIDTH  registered local salt.
- num_hashes  out  ADDR_MSB+2  registered hash count in use.
- cmp_config_applied  out  1  local config loaded; level.
- all_cmp_config_applied  in  1  one-cycle pulse from distributor.
- cfg_error  out  1  sticky: count exceeded capacity.

Behaviour:
- Reset (RST_N=0 at posedge): state IDLE; all outputs 0; salt, num_hashes, cfg_error cleared; word counter 0.
- IDLE: core_pause=0, cfg_ready=0. If new_cmp_config=1, go to DRAIN and assert core_pause=1 from the next cycle.
- DRAIN: core_pause=1. If core_idle=1, go to LOAD_SALT. Waiting is unbounded.
- LOAD_SALT: cfg_ready=1. On transfer, salt <= cfg_data[SALT_WIDTH-1:0]; go to LOAD_COUNT.
- LOAD_COUNT: cfg_ready=1. On transfer, let C = cfg_data[ADDR_MSB+1:0].
  - If C > 2^(ADDR_MSB+1): set cfg_error, num_hashes <= 2^(ADDR_MSB+1).
  - Otherwise num_hashes <= C.
  - Latch C as the remaining-word count. If C=0, go to APPLIED; else go to LOAD_HASHES with addr=0.
- LOAD_HASHES: cfg_ready=1. On each transfer:
  - If addr < capacity, mem_wr_en=1 the same cycle (registered, visible the next cycle) with mem_wr_addr=addr and mem_wr_data=cfg_data.
  - Otherwise the word is consumed with no write.
  - addr increments and remaining decrements. The transfer with remaining=1 goes to APPLIED.
  - mem_wr_en is a 1-cycle strobe per accepted word; gaps in cfg_valid stall without side effects.
- APPLIED: cfg_ready=0, core_pause=1, cmp_config_applied=1 (held). On all_cmp_config_applied=1: drop cmp_config_applied and core_pause the next cycle, and go to IDLE.
- new_cmp_config outside IDLE is ignored; it is not queued.
- all_cmp_config_applied outside APPLIED is ignored.
- cfg_valid while cfg_ready=0 is not consumed; the source holds it.
- cfg_error stays set until reset or the next successful LOAD_COUNT with C within capacity; it is cleared at that LOAD_COUNT transfer.
- Reset mid-load aborts everything. Memory contents are undefined but num_hashes=0, so the comparator sees an empty list.
- Latency, best case (core_idle already 1, cfg_valid constantly 1), from the new_cmp_config cycle to cmp_config_applied=1 with C hashes: 4+C cycles.
  - +1 to DRAIN, +1 to LOAD_SALT, +1 salt word, +1 count word, C hash words.
  - The APPLIED registered output appears on the cycle after the last transfer.
- No combinational path from cfg_valid to cfg_ready; cfg_ready depends only on state.

Test Plan:
- Basic: core_idle=1, pulse new_cmp_config, stream salt=0x5A3, count=3, hashes H0..H2 back-to-back.
  - mem writes at addr 0,1,2 with H0..H2; salt=0x5A3, num_hashes=3.
  - cmp_config_applied rises 7 cycles after the pulse; pulse all_cmp_config_applied, then applied=0 and core_pause=0 the next cycle.
- Drain stall: core_idle=0 for 20 cycles after new_cmp_config.
  - core_pause=1 throughout; cfg_ready=0 until one cycle after core_idle rises; no memory writes before that.
- Zero count: salt=1, count=0.
  - No mem_wr_en; num_hashes=0; cmp_config_applied=1 right after the count word.
- Overflow: ADDR_MSB=1 (capacity 4), count=6.
  - 6 words consumed, only addresses 0..3 written, num_hashes=4, cfg_error=1.
  - A following config with count=2 clears cfg_error.
- Bubbles and spurious inputs: cfg_valid toggling 1/0 during hashes, extra new_cmp_config pulses in LOAD_HASHES, all_cmp_config_applied pulses in DRAIN.
  - Exactly count writes with contiguous addresses; spurious pulses have no effect.
- Reset mid-load: RST_N=0 for one cycle after 2 of 5 hashes.
  - All outputs 0, state IDLE; the next full config completes normally.
